// File: rtl/cfg_reg_arbiter_pkg.sv
// cfg_pkg: shared constants and types for the configuration register arbiter.
// Register map addresses, reset value and the arbiter FSM state encoding.
package cfg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam logic [7:0] REG_RESET = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } arb_state_t;

endpackage

// File: rtl/cfg_reg_arbiter_if.sv
// cfg_reg_arbiter_if: one register-write requester port (valid/addr/data in,
// ready/err pulse out). master = requester side, slave = arbiter side.
interface cfg_reg_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) ();
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              err;

    modport master (output valid, addr, data, input ready, err);
    modport slave  (input valid, addr, data, output ready, err);
endinterface

// File: rtl/cfg_reg_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick. In: req[1:0], last_grant.
// Out: gnt_idx (winning port), gnt_valid (any request present).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_idx,
    output logic       gnt_valid
);
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            // contention: the port that did not win last time goes first
            2'b11:   gnt_idx = ~last_grant;
            default: gnt_idx = 1'b0;
        endcase
    end
endmodule

// File: rtl/cfg_reg_arbiter.sv
// cfg_reg_arbiter: owns five config registers, round-robin write arbitration
// between req0 (SPI) and req1 (sequencer); duty is double-buffered until pwm_period_start.
module cfg_reg_arbiter
    import cfg_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cfg_reg_arbiter_if.slave     req0,
    cfg_reg_arbiter_if.slave     req1,
    input  logic                 pwm_period_start,
    output logic [DATA_W-1:0]    en_reg_out_7_0,
    output logic [DATA_W-1:0]    en_reg_out_15_8,
    output logic [DATA_W-1:0]    en_reg_pwm_7_0,
    output logic [DATA_W-1:0]    en_reg_pwm_15_8,
    output logic [DATA_W-1:0]    pwm_duty_cycle,
    output logic                 duty_pending
);
    localparam logic [DATA_W-1:0] RST_V = DATA_W'(REG_RESET);

    arb_state_t        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        rdy_q, rdy_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] out_lo_q, out_lo_d;
    logic [DATA_W-1:0] out_hi_q, out_hi_d;
    logic [DATA_W-1:0] pwm_lo_q, pwm_lo_d;
    logic [DATA_W-1:0] pwm_hi_q, pwm_hi_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] duty_q, duty_d;
    logic              pend_q, pend_d;

    logic              gnt_idx;
    logic              gnt_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    function automatic logic bad_addr(input logic [ADDR_W-1:0] a);
        return a > ADDR_W'(ADDR_DUTY);
    endfunction

    rr_arb2 u_rr (
        .req        ({req1.valid, req0.valid}),
        .last_grant (last_grant_q),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    // ready/err are decided in IDLE and registered, so they pulse
    // during the GRANT cycle with no path from the inputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rdy_d        = 2'b00;
        err_d        = 2'b00;
        wr_en        = 1'b0;
        wr_addr      = req0.addr;
        wr_data      = req0.data;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    if (gnt_idx) begin
                        state_d  = GRANT1;
                        rdy_d[1] = 1'b1;
                        err_d[1] = bad_addr(req1.addr);
                    end else begin
                        state_d  = GRANT0;
                        rdy_d[0] = 1'b1;
                        err_d[0] = bad_addr(req0.addr);
                    end
                end
            end
            GRANT0: begin
                state_d = IDLE;
                if (req0.valid) begin
                    wr_en        = 1'b1;
                    last_grant_d = 1'b0;
                end
            end
            GRANT1: begin
                state_d = IDLE;
                wr_addr = req1.addr;
                wr_data = req1.data;
                if (req1.valid) begin
                    wr_en        = 1'b1;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_lo_d = out_lo_q;
        out_hi_d = out_hi_q;
        pwm_lo_d = pwm_lo_q;
        pwm_hi_d = pwm_hi_q;
        shadow_d = shadow_q;
        duty_d   = duty_q;
        pend_d   = pend_q;
        // commit takes the pre-edge shadow; a same-cycle duty write
        // below then re-arms pending with the new value
        if (pwm_period_start && pend_q) begin
            duty_d = shadow_q;
            pend_d = 1'b0;
        end
        if (wr_en) begin
            unique case (wr_addr)
                ADDR_W'(ADDR_EN_OUT_LO): out_lo_d = wr_data;
                ADDR_W'(ADDR_EN_OUT_HI): out_hi_d = wr_data;
                ADDR_W'(ADDR_EN_PWM_LO): pwm_lo_d = wr_data;
                ADDR_W'(ADDR_EN_PWM_HI): pwm_hi_d = wr_data;
                ADDR_W'(ADDR_DUTY): begin
                    shadow_d = wr_data;
                    pend_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            rdy_q        <= 2'b00;
            err_q        <= 2'b00;
            out_lo_q     <= RST_V;
            out_hi_q     <= RST_V;
            pwm_lo_q     <= RST_V;
            pwm_hi_q     <= RST_V;
            shadow_q     <= RST_V;
            duty_q       <= RST_V;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rdy_q        <= rdy_d;
            err_q        <= err_d;
            out_lo_q     <= out_lo_d;
            out_hi_q     <= out_hi_d;
            pwm_lo_q     <= pwm_lo_d;
            pwm_hi_q     <= pwm_hi_d;
            shadow_q     <= shadow_d;
            duty_q       <= duty_d;
            pend_q       <= pend_d;
        end
    end

    assign req0.ready      = rdy_q[0];
    assign req0.err        = err_q[0];
    assign req1.ready      = rdy_q[1];
    assign req1.err        = err_q[1];
    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign duty_pending    = pend_q;
endmodule
